// File: rtl/ft_fifo_bus_controller_pkg.sv
// Shared types and constants for the FT synchronous FIFO bus controller.
// Optional short-packet flush is enabled by defining FT_SHORT_PKT_EN.
package ft_ctrl_pkg;

    // One-hot controller states
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        RD_OE   = 5'b00010,
        RD_DATA = 5'b00100,
        TURN    = 5'b01000,
        WR_DATA = 5'b10000
    } ft_state_t;

    // Direction of the most recent grant
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Width of the packet statistics counters
    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/ft_fifo_bus_controller_arb.sv
// Round-robin direction arbiter: when both directions are ready, the one
// not served last wins. Powers up favouring READ on the first contest.
module ft_dir_arbiter
    import ft_ctrl_pkg::*;
(
    input  logic usb_clk,
    input  logic rst_n,
    input  logic rd_ok,
    input  logic wr_ok,
    input  logic accept,
    output logic grant_rd,
    output logic grant_wr
);

    logic last_dir;

    // Grant decode from readiness and the last served direction
    always_comb begin
        grant_rd = rd_ok & (!wr_ok | (last_dir == WRITE));
        grant_wr = wr_ok & (!rd_ok | (last_dir == READ));
    end

    // Remember the direction taken whenever the controller accepts a grant
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir <= WRITE;
        end else if (accept && grant_rd) begin
            last_dir <= READ;
        end else if (accept && grant_wr) begin
            last_dir <= WRITE;
        end
    end

endmodule

// File: rtl/ft_fifo_bus_controller.sv
// FT60x/FT245 synchronous FIFO bus controller: moves words between the FT
// bus and the local RX/TX FIFOs with fair direction arbitration, a bus
// turnaround gap after every burst and packet statistics.
// Define FT_SHORT_PKT_EN to flush partial TX packets after FLUSH_TIMEOUT.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no bus ownership, arbitrating between read and write
// RD_OE   | FT output enable asserted one cycle ahead of the read strobe
// RD_DATA | reading words while FT has data and RX FIFO has room
// TURN    | all strobes and drivers off for TURNAROUND cycles
// WR_DATA | driving TX words onto the bus, stalling while usb_txe is low
module ft_fifo_bus_controller
    import ft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BE_WIDTH      = DATA_WIDTH/8,
    parameter int PACKET_WORDS  = 1024,
    parameter int MAX_RD_BURST  = 1024,
    parameter int TURNAROUND    = 2,
    parameter int CNT_WIDTH     = 11,
    parameter int FLUSH_TIMEOUT = 256
) (
    input  logic                  usb_clk,
    input  logic                  rst_n,
    input  logic                  usb_rxf,
    input  logic                  usb_txe,
    output logic                  usb_rd,
    output logic                  usb_oe,
    output logic                  usb_wr,
    input  logic [DATA_WIDTH-1:0] usb_data_i,
    output logic [DATA_WIDTH-1:0] usb_data_o,
    output logic                  usb_data_oe,
    input  logic [BE_WIDTH-1:0]   usb_be_i,
    output logic [BE_WIDTH-1:0]   usb_be_o,
    input  logic                  tx_fifo_prog_empty,
    input  logic [CNT_WIDTH-1:0]  tx_fifo_count,
    input  logic [DATA_WIDTH-1:0] tx_fifo_data,
    output logic                  tx_fifo_read,
    input  logic                  rx_fifo_prog_full,
    output logic [DATA_WIDTH-1:0] rx_fifo_data,
    output logic [BE_WIDTH-1:0]   rx_fifo_be,
    output logic                  rx_fifo_write,
    output logic [STAT_WIDTH-1:0] rd_pkt_cnt,
    output logic [STAT_WIDTH-1:0] wr_pkt_cnt
);

    localparam int RW = $clog2(MAX_RD_BURST + 1);
    localparam int WW = $clog2(PACKET_WORDS + 1);
    localparam int TW = $clog2(TURNAROUND + 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(MAX_RD_BURST - 1);
    localparam logic [WW-1:0] PKT_FULL  = WW'(PACKET_WORDS);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND - 1);

    ft_state_t     state;
    logic [RW-1:0] rd_ctr;
    logic [WW-1:0] wr_ctr;
    logic [WW-1:0] wr_target;
    logic [WW-1:0] grant_target;
    logic [TW-1:0] turn_tmr;
    logic          rd_ok;
    logic          wr_ok;
    logic          flush_due;
    logic          grant_rd;
    logic          grant_wr;
    logic          rd_exit;
    logic          wr_last;

`ifdef FT_SHORT_PKT_EN
    localparam int FW = $clog2(FLUSH_TIMEOUT + 1);

    logic [FW-1:0] flush_tmr;
    logic          flush_arm;

    assign flush_arm = tx_fifo_prog_empty & (tx_fifo_count != '0);

    // Down-counter reloads while nothing is stranded, expires after
    // FLUSH_TIMEOUT consecutive cycles with a partial packet waiting
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_tmr <= FW'(FLUSH_TIMEOUT);
        end else if (!flush_arm) begin
            flush_tmr <= FW'(FLUSH_TIMEOUT);
        end else if (flush_tmr != '0) begin
            flush_tmr <= flush_tmr - FW'(1);
        end
    end

    assign flush_due    = flush_arm & (flush_tmr == '0);
    // A flush-driven grant only happens below PACKET_WORDS, so the count fits
    assign grant_target = tx_fifo_prog_empty ? WW'(tx_fifo_count) : PKT_FULL;
`else
    localparam int unused_flush_timeout = FLUSH_TIMEOUT;
    logic unused_tx_count;

    assign unused_tx_count = ^tx_fifo_count;
    assign flush_due       = 1'b0;
    assign grant_target    = PKT_FULL;
`endif

    assign rd_ok = usb_rxf & !rx_fifo_prog_full;
    assign wr_ok = usb_txe & (!tx_fifo_prog_empty | flush_due);

    ft_dir_arbiter u_arb (
        .usb_clk  (usb_clk),
        .rst_n    (rst_n),
        .rd_ok    (rd_ok),
        .wr_ok    (wr_ok),
        .accept   (state == IDLE),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // Strobes drop in the very cycle FT runs dry, RX fills or TX stalls
    always_comb begin
        usb_rd       = (state == RD_DATA) & rd_ok;
        usb_wr       = (state == WR_DATA) & usb_txe & (wr_ctr < wr_target);
        tx_fifo_read = usb_wr;
        rd_exit      = (state == RD_DATA) & (!rd_ok | (usb_rd & (rd_ctr == RD_LAST)));
        wr_last      = usb_wr & (wr_ctr == (wr_target - WW'(1)));
        usb_data_o   = usb_data_oe ? tx_fifo_data : '0;
        usb_be_o     = {BE_WIDTH{usb_data_oe}};
    end

    // Registered RX push, one cycle behind the bus sample
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_fifo_write <= 1'b0;
            rx_fifo_data  <= '0;
            rx_fifo_be    <= '0;
        end else begin
            rx_fifo_write <= usb_rd;
            if (usb_rd) begin
                rx_fifo_data <= usb_data_i;
                rx_fifo_be   <= usb_be_i;
            end
        end
    end

    // Bus sequencing FSM with burst counters and packet statistics
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            usb_oe      <= 1'b0;
            usb_data_oe <= 1'b0;
            rd_ctr      <= '0;
            wr_ctr      <= '0;
            wr_target   <= '0;
            turn_tmr    <= '0;
            rd_pkt_cnt  <= '0;
            wr_pkt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state  <= RD_OE;
                        usb_oe <= 1'b1;
                        rd_ctr <= '0;
                    end else if (grant_wr) begin
                        state       <= WR_DATA;
                        usb_data_oe <= 1'b1;
                        wr_ctr      <= '0;
                        wr_target   <= grant_target;
                    end
                end
                RD_OE: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (usb_rd) begin
                        rd_ctr <= rd_ctr + RW'(1);
                    end
                    if (rd_exit) begin
                        state    <= TURN;
                        usb_oe   <= 1'b0;
                        turn_tmr <= TURN_LOAD;
                        if (usb_rd || (rd_ctr != '0)) begin
                            rd_pkt_cnt <= rd_pkt_cnt + STAT_WIDTH'(1);
                        end
                    end
                end
                WR_DATA: begin
                    if (usb_wr) begin
                        wr_ctr <= wr_ctr + WW'(1);
                    end
                    if (wr_last) begin
                        state       <= TURN;
                        usb_data_oe <= 1'b0;
                        turn_tmr    <= TURN_LOAD;
                        wr_pkt_cnt  <= wr_pkt_cnt + STAT_WIDTH'(1);
                    end
                end
                TURN: begin
                    if (turn_tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        turn_tmr <= turn_tmr - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ft_fifo_bus_controller.md
Name: ft_fifo_bus_controller

Overview:
Parametrised successor to the FT245-style FIFO bus controller. It moves data between the FT60x/FT245 synchronous FIFO bus and the master RX/TX FIFOs, configurable in bus width, packet size and read burst limit. It adds fair round-robin direction arbitration, a bus turnaround phase, byte-enable capture on reads, write stalls on usb_txe, and packet statistics. The pad tristate sits at top level; this block drives split in/out/oe data buses.

Parameters:
DATA_WIDTH, 32, FT bus width in bits (16 or 32).
BE_WIDTH, DATA_WIDTH/8, byte-enable width.
PACKET_WORDS, 1024, words per write packet (≥2).
MAX_RD_BURST, 1024, maximum words per read burst before re-arbitration (≥1).
TURNAROUND, 2, idle cycles after each burst (≥1).
CNT_WIDTH, 11, width of tx_fifo_count.
FLUSH_TIMEOUT, 256, short-packet timeout in cycles (only with FT_SHORT_PKT_EN).

Ports:
usb_clk  in  1  FT bus clock, sole clock.
rst_n  in  1  asynchronous active-low reset.
usb_rxf  in  1  FT has read data (active-high at this boundary).
usb_txe  in  1  FT has write space (active-high).
usb_rd  out  1  read strobe.
usb_oe  out  1  FT output enable.
usb_wr  out  1  write strobe.
usb_data_i  in  DATA_WIDTH  bus data from pads.
usb_data_o  out  DATA_WIDTH  bus data to pads.
usb_data_oe  out  1  pad drive enable for usb_data_o/usb_be_o.
usb_be_i  in  BE_WIDTH  byte enables from pads.
usb_be_o  out  BE_WIDTH  byte enables to pads.
tx_fifo_prog_empty  in  1  fewer than PACKET_WORDS words available.
tx_fifo_count  in  CNT_WIDTH  TX FIFO fill level (used only with FT_SHORT_PKT_EN).
tx_fifo_data  in  DATA_WIDTH  FWFT TX head word.
tx_fifo_read  out  1  TX pop.
rx_fifo_prog_full  in  1  RX FIFO nearly full.
rx_fifo_data  out  DATA_WIDTH  RX push data.
rx_fifo_be  out  BE_WIDTH  RX push byte enables.
rx_fifo_write  out  1  RX push.
rd_pkt_cnt  out  16  completed read bursts, wraps.
wr_pkt_cnt  out  16  completed write packets, wraps.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all strobes, usb_data_oe, rx_fifo_write and counters 0; usb_data_o/usb_be_o 0; last_dir=WRITE, so the first contested grant goes to read.
- rd_ok = usb_rxf & !rx_fifo_prog_full. wr_ok = usb_txe & !tx_fifo_prog_empty.
- IDLE: if both are ok, serve opposite of last_dir; else serve whichever is ok; else stay. The grant updates last_dir.
- RD_OE (1 cycle): usb_oe=1, usb_rd=0, usb_data_oe=0. Then RD_DATA.
- RD_DATA: usb_oe=1, usb_rd=1. A word is taken on each edge with usb_rd & usb_rxf.
  - RX path is registered: rx_fifo_write/data/be appear 1 cycle after sampling.
  - Leave to TURN when !usb_rxf, rx_fifo_prog_full, or rd_ctr==MAX_RD_BURST-1 on a taken word. usb_rd deasserts that cycle.
  - On exit with ≥1 word, rd_pkt_cnt += 1.
- WR_DATA: usb_data_oe=1, usb_be_o all ones, usb_data_o=tx_fifo_data.
  - usb_wr = tx_fifo_read = usb_txe & (wr_ctr<target), combinational. target=PACKET_WORDS.
  - If usb_txe drops mid-packet: stall in WR_DATA, no pop, data held.
  - When wr_ctr reaches target: wr_pkt_cnt += 1, go to TURN.
- TURN: all strobes 0, usb_data_oe=0, for TURNAROUND cycles, then IDLE. usb_data_oe never overlaps usb_oe.
- Counters rd_ctr/wr_ctr use width $clog2(max+1) and clear on entry to RD_OE/WR_DATA. Stat counters wrap 0xFFFF→0.
- rst_n asserted mid-burst: immediate return to reset values. The partial packet is not counted.

Optional Feature:
FT_SHORT_PKT_EN.
- Defined: a timer counts cycles with tx_fifo_prog_empty=1 & tx_fifo_count>0 and clears otherwise. At FLUSH_TIMEOUT with usb_txe=1 it makes wr_ok true. WR_DATA then uses target=tx_fifo_count snapshot at grant. Arbitration is unchanged.
- Undefined: tx_fifo_count is ignored and only full PACKET_WORDS packets are written.

Decomposition:
- Package ft_ctrl_pkg: one-hot state localparams (IDLE, RD_OE, RD_DATA, TURN, WR_DATA), direction constants READ/WRITE, stat width 16.
- One natural sub-module: ft_dir_arbiter (rd_ok, wr_ok, last_dir → grant), combinational plus last_dir register.

Test Plan:
- Reset idle: rst_n=0 then 1, rxf=txe=0 → all strobes 0, usb_data_oe=0, state IDLE indefinitely.
- Read burst: rxf=1 for 5 words then 0 → usb_oe 1 cycle before usb_rd; 5 rx_fifo_write pulses 1 cycle delayed with matching data/be (be=4'b0011 on last); rd_pkt_cnt=1.
- Write packet, PACKET_WORDS=8, txe stalls 2 cycles at word 4 → exactly 8 usb_wr/tx_fifo_read, no pops during stall, wr_pkt_cnt=1, then TURNAROUND idle cycles.
- Fairness: rd_ok and wr_ok constantly 1, MAX_RD_BURST=4 → grants alternate R,W,R,W; read bursts are 4 words; usb_data_oe and usb_oe are never both 1.
- rx_fifo_prog_full rises on read word 3 → usb_rd drops that cycle, exactly 3 writes, TURN.
- FT_SHORT_PKT_EN, FLUSH_TIMEOUT=16, tx_fifo_count=3, prog_empty=1 → after 16 cycles, 3-word packet written, wr_pkt_cnt=1. Without macro → no write.
